// File: rtl/axis_stream_fifo.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : axis_stream_fifo
// Brief    : First-word-fall-through AXI-Stream FIFO carrying tdata + tlast,
//            with beat occupancy and stored-packet count. Define
//            AXIS_FIFO_PACKET_MODE_EN for store-and-forward output gating.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module axis_stream_fifo #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 8,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast,
  output logic [AW:0]       count,
  output logic [AW:0]       pkt_count
);

  localparam logic [AW:0]   C_FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_ONE     = (AW+1)'(1);
  localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

  logic [DATA_W:0]  r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [AW:0]      r_pkt_count;
  logic [DATA_W:0]  w_head;
  logic             w_wr;
  logic             w_rd;
  logic             w_nonempty;
  logic             w_pkt_inc;
  logic             w_pkt_dec;

  assign w_head     = r_mem[r_rd_ptr];
  assign m_tdata    = w_head[DATA_W-1:0];
  assign m_tlast    = w_head[DATA_W];
  assign w_nonempty = (r_count != '0);

  // Full is decided from the registered count only, so a read in the same
  // cycle never opens the input while full.
  assign s_tready   = !reset && (r_count != C_FULL);

  assign w_wr       = s_tvalid && s_tready;
  assign w_rd       = m_tvalid && m_tready;
  assign w_pkt_inc  = w_wr && s_tlast;
  assign w_pkt_dec  = w_rd && m_tlast;

`ifdef AXIS_FIFO_PACKET_MODE_EN
  logic r_in_packet;

  // Open the gate once a whole packet is stored, when full (oversize packet
  // escape), or while the rest of an already-started packet is draining.
  assign m_tvalid = w_nonempty &&
                    ((r_pkt_count != '0) || (r_count == C_FULL) || r_in_packet);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_packet <= 1'b0;
    end else if (w_rd) begin
      r_in_packet <= !m_tlast;
    end
  end
`else
  assign m_tvalid = w_nonempty;
`endif

  // Storage is not reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {s_tlast, s_tdata};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_pkt_count <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
      case ({w_pkt_inc, w_pkt_dec})
        2'b10:   r_pkt_count <= r_pkt_count + C_ONE;
        2'b01:   r_pkt_count <= r_pkt_count - C_ONE;
        default: r_pkt_count <= r_pkt_count;
      endcase
    end
  end

  assign count     = r_count;
  assign pkt_count = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_axis_stream_fifo.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_axis_stream_fifo
// Brief    : Scoreboard bench for axis_stream_fifo (cut-through by default,
//            store-and-forward checks when AXIS_FIFO_PACKET_MODE_EN is set).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_axis_stream_fifo;

  logic        clk;
  logic        reset;
  logic        s_tvalid;
  logic        s_tready;
  logic [15:0] s_tdata;
  logic        s_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic [15:0] m_tdata;
  logic        m_tlast;
  logic [3:0]  count;
  logic [3:0]  pkt_count;

  logic        r_rdy;
  logic        r_bp_mode;
  logic        r_rnd;

  int          checks;
  int          errors;
  logic [16:0] exp_q[$];

  logic        prev_stall;
  logic [15:0] prev_data;
  logic        prev_last;

  axis_stream_fifo #(.DATA_W(16), .DEPTH(8)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tdata   (s_tdata),
    .s_tlast   (s_tlast),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tdata   (m_tdata),
    .m_tlast   (m_tlast),
    .count     (count),
    .pkt_count (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign m_tready = r_bp_mode ? r_rnd : r_rdy;

  initial r_rnd = 1'b0;
  always begin
    @(posedge clk);
    #1;
    r_rnd = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every handshake and enforces
  // that a stalled head beat holds valid and data.
  initial begin
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
  end
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold", {15'd0, m_tvalid, m_tlast, m_tdata},
              {15'd0, 1'b1, prev_last, prev_data});
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {15'd0, m_tlast, m_tdata}, 32'hFFFF_FFFF);
        end else begin
          check("beat", {15'd0, m_tlast, m_tdata}, {15'd0, exp_q.pop_front()});
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
    end
  end

  task automatic send(input logic [15:0] d, input logic l);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    while (!ok && n < 500) begin
      @(negedge clk);
      if (s_tready) ok = 1'b1;
      else n++;
    end
    if (ok) begin
      exp_q.push_back({l, d});
      @(posedge clk);
      #1;
    end else begin
      check("send_timeout", 32'(d), 32'hFFFF_FFFF);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while ((count != 0 || exp_q.size() != 0) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, {27'd0, count, 1'b0} | 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    s_tvalid  = 1'b0;
    s_tdata   = '0;
    s_tlast   = 1'b0;
    r_rdy     = 1'b0;
    r_bp_mode = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_tready", 32'(s_tready), 32'd0);
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_pkt_count", 32'(pkt_count), 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_s_tready", 32'(s_tready), 32'd1);

    // Single beat, one-cycle latency
    r_rdy = 1'b1;
    send(16'h00A5, 1'b1);
    check("single_latency_valid", 32'(m_tvalid), 32'd1);
    check("single_count", 32'(count), 32'd1);
    check("single_pkt", 32'(pkt_count), 32'd1);
    @(posedge clk);
    #1;
    check("single_count_after", 32'(count), 32'd0);
    check("single_pkt_after", 32'(pkt_count), 32'd0);
    check("single_valid_after", 32'(m_tvalid), 32'd0);

    // Fill to full, hold the 9th beat until one read
    r_rdy = 1'b0;
    for (int i = 1; i <= 8; i++) send(16'(i), i == 8);
    check("full_count", 32'(count), 32'd8);
    check("full_s_tready", 32'(s_tready), 32'd0);
    check("full_pkt", 32'(pkt_count), 32'd1);
    fork
      send(16'd9, 1'b1);
      begin
        repeat (3) @(posedge clk);
        #1;
        check("full_hold_count", 32'(count), 32'd8);
        r_rdy = 1'b1;
      end
    join
    wait_empty("full_drain");
    check("full_drain_pkt", 32'(pkt_count), 32'd0);

    // Streaming 20-beat packet at one beat per clock
    for (int i = 1; i <= 20; i++) begin
      send(16'(16'h0100 + i), i == 20);
`ifndef AXIS_FIFO_PACKET_MODE_EN
      check("stream_count", 32'(count), 32'd1);
`endif
    end
    wait_empty("stream_drain");

    // Random backpressure, 4 packets of 25 beats
    r_bp_mode = 1'b1;
    for (int i = 0; i < 100; i++) begin
      send(16'(16'h2000 + i), (i % 25) == 24);
      check("bp_pkt_le4", 32'(pkt_count <= 4), 32'd1);
    end
    wait_empty("bp_drain");
    r_bp_mode = 1'b0;
    check("bp_pkt_end", 32'(pkt_count), 32'd0);

    // Reset asserted mid-packet, mid-cycle
    r_rdy = 1'b0;
    for (int i = 0; i < 3; i++) send(16'(16'h3000 + i), 1'b0);
    check("mid_count_before", 32'(count), 32'd3);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(m_tvalid), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_pkt", 32'(pkt_count), 32'd0);
    check("mid_rst_s_tready", 32'(s_tready), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    r_rdy = 1'b1;
    send(16'h1234, 1'b1);
    wait_empty("mid_rst_drain");

`ifdef AXIS_FIFO_PACKET_MODE_EN
    // Store-and-forward: gate opens on the packet's last write
    send(16'h4001, 1'b0);
    check("pm_gate1", 32'(m_tvalid), 32'd0);
    send(16'h4002, 1'b0);
    check("pm_gate2", 32'(m_tvalid), 32'd0);
    send(16'h4003, 1'b1);
    check("pm_open", 32'(m_tvalid), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("pm_consecutive", 32'(count), 32'd0);
    // Oversize packet escapes once full
    for (int i = 1; i <= 7; i++) send(16'(16'h5000 + i), 1'b0);
    check("pm_big_gate", 32'(m_tvalid), 32'd0);
    send(16'h5008, 1'b0);
    check("pm_big_open", 32'(m_tvalid), 32'd1);
    check("pm_big_count", 32'(count), 32'd8);
    send(16'h5009, 1'b0);
    send(16'h500A, 1'b1);
    wait_empty("pm_big_drain");
`endif

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
